// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, NZCV flags, shifts/rotates.
// Optional multi-cycle shift-add unsigned multiplier (op E) enabled by macro ALU_MUL_EN.
// Without ALU_MUL_EN, op E executes as the reserved op and y_hi is tied to zero.
module alu_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_hi,
   output logic [3:0]       flags,
   output logic             err
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned W2  = 2 * WIDTH;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_ADDC = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_SUBC = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_NOT  = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_SAR  = 4'hA;
   localparam logic [3:0] OP_ROL  = 4'hB;
   localparam logic [3:0] OP_PASS = 4'hC;
   localparam logic [3:0] OP_INC  = 4'hD;

   // Signed overflow: the exact signed result does not fit in WIDTH bits
   function automatic logic ovf(input logic [WIDTH+1:0] s);
      return !((s[WIDTH+1] == s[WIDTH]) && (s[WIDTH] == s[WIDTH-1]));
   endfunction

   // Output register
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [3:0]       flags_q, flags_d;
   logic             err_q, err_d;
   logic             accept_c;
   logic             busy_c;

   // Single-cycle datapath
   logic [SHW-1:0]   amt_c;
   logic [WIDTH-1:0] add_b_c;
   logic             add_ci_c, sub_ci_c;
   logic [WIDTH:0]   add_u_c, sub_u_c;
   logic [WIDTH+1:0] add_s_c, sub_s_c;
   logic [W2-1:0]    shl_c, shr_c, sar_c, rol_c;
   logic [WIDTH-1:0] alu_y_c;
   logic             alu_c_c, alu_v_c, alu_err_c;
   logic [3:0]       alu_flags_c;

`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'hE;

   typedef enum logic [0:0] {S_IDLE, S_MUL} state_e;

   state_e           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] y_hi_q, y_hi_d;
   logic [WIDTH:0]   mul_sum_c;
   logic [W2-1:0]    mul_step_c;

   assign busy_c = (state_q == S_MUL);
   assign y_hi   = y_hi_q;
`else
   assign busy_c = 1'b0;
   assign y_hi   = '0;
`endif

   assign in_ready  = !rst && !busy_c && (!out_valid_q || out_ready);
   assign accept_c  = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign flags     = flags_q;
   assign err       = err_q;

   // Adder/subtractor and shifter operands shared by the single-cycle ops
   assign amt_c    = b[SHW-1:0];
   assign add_b_c  = (op == OP_INC) ? WIDTH'(1) : b;
   assign add_ci_c = (op == OP_ADDC) ? cin : 1'b0;
   assign sub_ci_c = (op == OP_SUBC) ? cin : 1'b0;
   assign add_u_c  = {1'b0, a} + {1'b0, add_b_c} + (WIDTH+1)'(add_ci_c);
   assign sub_u_c  = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(sub_ci_c);
   assign add_s_c  = {{2{a[WIDTH-1]}}, a} + {{2{add_b_c[WIDTH-1]}}, add_b_c}
                     + (WIDTH+2)'(add_ci_c);
   assign sub_s_c  = {{2{a[WIDTH-1]}}, a} - {{2{b[WIDTH-1]}}, b}
                     - (WIDTH+2)'(sub_ci_c);
   assign shl_c    = {WIDTH'(0), a} << amt_c;
   assign shr_c    = {a, WIDTH'(0)} >> amt_c;
   assign sar_c    = W2'($signed({a, WIDTH'(0)}) >>> amt_c);
   assign rol_c    = {a, a} << amt_c;

   // Single-cycle result and flags; the bit shifted out lands next to the kept window
   always_comb begin
      alu_y_c   = '0;
      alu_c_c   = 1'b0;
      alu_v_c   = 1'b0;
      alu_err_c = 1'b0;
      case (op)
         OP_ADD, OP_ADDC, OP_INC: begin
            alu_y_c = add_u_c[WIDTH-1:0];
            alu_c_c = add_u_c[WIDTH];
            alu_v_c = ovf(add_s_c);
         end
         OP_SUB, OP_SUBC: begin
            alu_y_c = sub_u_c[WIDTH-1:0];
            alu_c_c = sub_u_c[WIDTH];
            alu_v_c = ovf(sub_s_c);
         end
         OP_AND:  alu_y_c = a & b;
         OP_OR:   alu_y_c = a | b;
         OP_XOR:  alu_y_c = a ^ b;
         OP_NOT:  alu_y_c = ~a;
         OP_SHL: begin
            alu_y_c = shl_c[WIDTH-1:0];
            alu_c_c = shl_c[WIDTH];
         end
         OP_SHR: begin
            alu_y_c = shr_c[W2-1:WIDTH];
            alu_c_c = shr_c[WIDTH-1];
         end
         OP_SAR: begin
            alu_y_c = sar_c[W2-1:WIDTH];
            alu_c_c = sar_c[WIDTH-1];
         end
         OP_ROL: begin
            alu_y_c = rol_c[W2-1:WIDTH];
            alu_c_c = (amt_c != '0) ? rol_c[WIDTH] : 1'b0;
         end
         OP_PASS: alu_y_c = b;
         default: alu_err_c = 1'b1;
      endcase
      alu_flags_c = {alu_y_c[WIDTH-1], (alu_y_c == '0), alu_c_c, alu_v_c};
   end

`ifdef ALU_MUL_EN
   // One shift-add step: add multiplicand into the high half when the multiplier LSB is set
   always_comb begin
      mul_sum_c  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      mul_step_c = {mul_sum_c, acc_q[WIDTH-1:1]};
   end
`endif

   // Next-state: output handshake, op accept and multiplier sequencing
   always_comb begin
      out_valid_d = out_valid_q;
      y_d         = y_q;
      flags_d     = flags_q;
      err_d       = err_q;
`ifdef ALU_MUL_EN
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      y_hi_d      = y_hi_q;
`endif
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept_c) begin
`ifdef ALU_MUL_EN
         if (op == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = '0;
            acc_d   = {WIDTH'(0), b};
            mcand_d = a;
         end else begin
            y_d         = alu_y_c;
            y_hi_d      = '0;
            flags_d     = alu_flags_c;
            err_d       = alu_err_c;
            out_valid_d = 1'b1;
         end
`else
         y_d         = alu_y_c;
         flags_d     = alu_flags_c;
         err_d       = alu_err_c;
         out_valid_d = 1'b1;
`endif
      end
`ifdef ALU_MUL_EN
      if (state_q == S_MUL) begin
         acc_d = mul_step_c;
         cnt_d = cnt_q + SHW'(1);
         if (cnt_q == SHW'(WIDTH - 1)) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            y_d         = mul_step_c[WIDTH-1:0];
            y_hi_d      = mul_step_c[W2-1:WIDTH];
            flags_d     = {mul_step_c[W2-1], (mul_step_c == '0),
                           (mul_step_c[W2-1:WIDTH] != '0), 1'b0};
            err_d       = 1'b0;
            out_valid_d = 1'b1;
         end
      end
`endif
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         flags_q     <= '0;
         err_q       <= 1'b0;
`ifdef ALU_MUL_EN
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         y_hi_q      <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         flags_q     <= flags_d;
         err_q       <= err_d;
`ifdef ALU_MUL_EN
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         y_hi_q      <= y_hi_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, multi-cycle corner sequences and a randomized
// scoreboard run against an integer-arithmetic reference model (WIDTH=8).
module tb_alu_seq;

   localparam int W = 8;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a, b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y, y_hi;
   logic [3:0]   flags;
   logic         err;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int y;
      int hi;
      int fl;
      int err;
   } res_t;

   typedef struct {
      int op;
      int a;
      int b;
      int cin;
      int y;
      int fl;
      int err;
   } vec_t;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .y_hi      (y_hi),
      .flags     (flags),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain integer arithmetic from the operation definitions
   function automatic res_t model(input int o, input int av, input int bv, input int ci);
      res_t r;
      int full, sa, sb, sr, n, p, c, v, bb;
      r = '{0, 0, 0, 0};
      c = 0;
      v = 0;
      n = bv % W;
      sa = (av >= 128) ? av - 256 : av;
      sb = (bv >= 128) ? bv - 256 : bv;
      case (o)
         0, 1, 13: begin
            bb = (o == 13) ? 1 : bv;
            if (o == 13) sb = 1;
            if (o != 1) ci = 0;
            full = av + bb + ci;
            r.y = full % 256;
            c = (full > 255) ? 1 : 0;
            sr = sa + sb + ci;
            v = (sr > 127 || sr < -128) ? 1 : 0;
         end
         2, 3: begin
            if (o != 3) ci = 0;
            full = av - bv - ci;
            r.y = full & 255;
            c = (full < 0) ? 1 : 0;
            sr = sa - sb - ci;
            v = (sr > 127 || sr < -128) ? 1 : 0;
         end
         4: r.y = av & bv;
         5: r.y = av | bv;
         6: r.y = av ^ bv;
         7: r.y = (~av) & 255;
         8: begin
            r.y = (av << n) & 255;
            c = (n != 0) ? ((av >> (W - n)) & 1) : 0;
         end
         9: begin
            r.y = av >> n;
            c = (n != 0) ? ((av >> (n - 1)) & 1) : 0;
         end
         10: begin
            r.y = (sa >>> n) & 255;
            c = (n != 0) ? ((av >> (n - 1)) & 1) : 0;
         end
         11: begin
            r.y = ((av << n) | (av >> (W - n))) & 255;
            c = (n != 0) ? (r.y & 1) : 0;
         end
         12: r.y = bv;
         default: r.err = 1;
      endcase
      if (o == 14 && MUL_EN) begin
         p = av * bv;
         r.y = p % 256;
         r.hi = p / 256;
         r.err = 0;
         r.fl = ((r.hi >= 128) ? 8 : 0) + ((p == 0) ? 4 : 0) + ((r.hi != 0) ? 2 : 0);
      end else begin
         r.fl = ((r.y >= 128) ? 8 : 0) + ((r.y == 0) ? 4 : 0) + c * 2 + v;
      end
      return r;
   endfunction

   task automatic wait_ready(input string name);
      int n = 0;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) chk({name, "_ready_timeout"}, 0, 1);
   endtask

   // Drive one op and let it be accepted at the next edge
   task automatic issue(input int o, input int av, input int bv, input int ci);
      op = 4'(o);
      a = W'(av);
      b = W'(bv);
      cin = 1'(ci);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      op = 4'($urandom);
      a = W'($urandom);
      b = W'($urandom);
   endtask

   vec_t vt[13];
   res_t q[$];

   initial begin
      int n, bad, lat;
      logic acc, xfer, hold;
      logic [W-1:0] sy;
      logic [3:0] sf;
      res_t e;

      vt[0]  = '{1,  45,   34,   1, 8'h50, 4'b0000, 0};
      vt[1]  = '{2,  34,   45,   0, 8'hF5, 4'b1010, 0};
      vt[2]  = '{0,  100,  100,  0, 8'hC8, 4'b1001, 0};
      vt[3]  = '{8,  8'h81, 1,   0, 8'h02, 4'b0010, 0};
      vt[4]  = '{10, 8'h80, 3,   0, 8'hF0, 4'b1000, 0};
      vt[5]  = '{11, 8'h81, 1,   0, 8'h03, 4'b0010, 0};
      vt[6]  = '{15, 8'h12, 8'h34, 1, 8'h00, 4'b0100, 1};
      vt[7]  = '{3,  8'h80, 8'h00, 1, 8'h7F, 4'b0001, 0};
      vt[8]  = '{13, 8'hFF, 8'h00, 0, 8'h00, 4'b0110, 0};
      vt[9]  = '{6,  8'hAA, 8'hAA, 0, 8'h00, 4'b0100, 0};
      vt[10] = '{12, 8'h00, 8'h80, 0, 8'h80, 4'b1000, 0};
      vt[11] = '{9,  8'h01, 8'h01, 0, 8'h00, 4'b0110, 0};
      vt[12] = '{7,  8'h0F, 8'h00, 0, 8'hF0, 4'b1000, 0};

      rst = 1'b1;
      in_valid = 1'b0;
      op = '0;
      a = '0;
      b = '0;
      cin = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_y_hi", int'(y_hi), 0);
      chk("rst_flags", int'(flags), 0);
      chk("rst_err", int'(err), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", int'(in_ready), 1);

      // Directed vector table
      for (int i = 0; i < 13; i++) begin
         out_ready = 1'b1;
         wait_ready("vec");
         issue(vt[i].op, vt[i].a, vt[i].b, vt[i].cin);
         chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
         chk($sformatf("vec%0d_y", i), int'(y), vt[i].y);
         chk($sformatf("vec%0d_y_hi", i), int'(y_hi), 0);
         chk($sformatf("vec%0d_flags", i), int'(flags), vt[i].fl);
         chk($sformatf("vec%0d_err", i), int'(err), vt[i].err);
      end
      step();
      chk("drop_after_xfer", int'(out_valid), 0);

      // Multiply latency and result (single-cycle reserved without the multiplier)
      out_ready = 1'b1;
      wait_ready("mul");
      issue(14, 45, 34, 0);
      n = 0;
      bad = 0;
      while (!out_valid && n < 20) begin
         if (in_ready) bad++;
         step();
         n++;
      end
      lat = MUL_EN ? W : 0;
      chk("mul_latency", n, lat);
      chk("mul_in_ready_low", bad, 0);
      chk("mul_y", int'(y), MUL_EN ? 8'hFA : 0);
      chk("mul_y_hi", int'(y_hi), MUL_EN ? 8'h05 : 0);
      chk("mul_flags", int'(flags), MUL_EN ? 4'b0010 : 4'b0100);
      chk("mul_err", int'(err), MUL_EN ? 0 : 1);

      // Backpressure: result held while out_ready=0, queued op taken on transfer
      step();
      wait_ready("bp");
      out_ready = 1'b0;
      issue(0, 1, 2, 0);
      op = 4'(2);
      a = W'(5);
      b = W'(3);
      cin = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready", int'(in_ready), 0);
         step();
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_y", int'(y), 3);
         chk("bp_flags", int'(flags), 0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", int'(in_ready), 1);
      step();
      in_valid = 1'b0;
      chk("bp_next_valid", int'(out_valid), 1);
      chk("bp_next_y", int'(y), 2);
      chk("bp_next_flags", int'(flags), 0);
      step();
      chk("bp_drop", int'(out_valid), 0);

      // Reset in the middle of an op (aborts the multiply when present)
      wait_ready("rstmul");
      issue(14, 45, 34, 0);
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      chk("rm_in_ready", int'(in_ready), 0);
      chk("rm_valid", int'(out_valid), 0);
      chk("rm_y", int'(y), 0);
      chk("rm_y_hi", int'(y_hi), 0);
      chk("rm_flags", int'(flags), 0);
      chk("rm_err", int'(err), 0);
      rst = 1'b0;
      #1;
      chk("rm_ready_after", int'(in_ready), 1);
      out_ready = 1'b1;
      bad = 0;
      for (int k = 0; k < W + 4; k++) begin
         step();
         if (out_valid) bad++;
      end
      chk("rm_no_result", bad, 0);

      // Randomized traffic against the reference model
      q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         in_valid = ($urandom % 4) != 0;
         op = 4'($urandom);
         a = W'($urandom);
         b = W'($urandom);
         cin = 1'($urandom);
         out_ready = ($urandom % 4) != 0;
         #1;
         acc = in_valid && in_ready;
         xfer = out_valid && out_ready;
         hold = out_valid && !out_ready;
         if (xfer) begin
            if (q.size() == 0) begin
               chk("rnd_unexpected_result", 1, 0);
            end else begin
               e = q.pop_front();
               chk("rnd_y", int'(y), e.y);
               chk("rnd_y_hi", int'(y_hi), e.hi);
               chk("rnd_flags", int'(flags), e.fl);
               chk("rnd_err", int'(err), e.err);
            end
         end
         if (acc) begin
            chk("rnd_one_in_flight", q.size(), 0);
            q.push_back(model(int'(op), int'(a), int'(b), int'(cin)));
         end
         sy = y;
         sf = flags;
         step();
         if (hold) begin
            chk("rnd_hold_valid", int'(out_valid), 1);
            chk("rnd_hold_y", int'(y), int'(sy));
            chk("rnd_hold_flags", int'(flags), int'(sf));
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (out_valid && q.size() != 0) begin
            e = q.pop_front();
            chk("drain_y", int'(y), e.y);
            chk("drain_y_hi", int'(y_hi), e.hi);
            chk("drain_flags", int'(flags), e.fl);
            chk("drain_err", int'(err), e.err);
         end
         step();
      end
      chk("drain_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
